// File: rtl/aib_wb_rsp_pkg.sv
// Shared types and helpers for the aib_wb_rsp Wishbone responder.
package aib_wb_rsp_pkg;

  localparam int LAT_MAX    = 8;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic [31:0] byte_merge(input logic [31:0]           old,
                                             input logic [31:0]           wdata,
                                             input logic [WORD_BYTES-1:0] sel);
    logic [31:0] m;
    for (int b = 0; b < WORD_BYTES; b++) m[8*b +: 8] = {8{sel[b]}};
    return (old & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/aib_wb_rsp_pipe.sv
// LATENCY-deep response shift register; o_retire flags the entry that
// lands in the output stage on the next edge.
module aib_wb_rsp_pipe
  import aib_wb_rsp_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  rsp_t i_rsp,
  output rsp_t o_rsp,
  output logic o_retire
);

  rsp_t [LATENCY-1:0] stg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= i_rsp;
      for (int s = 1; s < LATENCY; s++) stg[s] <= stg[s-1];
    end
  end

  assign o_rsp = stg[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_l1
      assign o_retire = i_rsp.valid;
    end else begin : g_ln
      assign o_retire = stg[LATENCY-2].valid;
    end
  endgenerate

endmodule

// File: rtl/aib_wb_rsp.sv
// Pipelined Wishbone responder with scratch memory, fixed ack latency and
// stall throttling. Define AIB_WB_RSP_ADDR_ERR_EN for out-of-range o_err.
module aib_wb_rsp
  import aib_wb_rsp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int CNT_W = $clog2(LAT_MAX + 1);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc;
  logic              addr_err;
  logic              retire;
  logic              unused_addr;
  rsp_t              rsp_d;
  rsp_t              rsp_q;

  assign idx         = i_addr[ADDR_W+1:2];
  assign unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};
  assign o_stall     = (cnt_q == CNT_W'(MAX_OUT));
  assign acc         = i_stb & ~o_stall;

`ifdef AIB_WB_RSP_ADDR_ERR_EN
  assign addr_err = |i_addr[31:ADDR_W+2];
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (acc && i_we && !addr_err) mem[idx] <= byte_merge(mem[idx], i_wdata, i_sel);
  end

  // Only clean reads carry data; write and error responses return zero.
  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = acc;
    rsp_d.err   = acc & addr_err;
    if (acc && !i_we && !addr_err) rsp_d.rdata = mem[idx];
  end

  aib_wb_rsp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rsp    (rsp_d),
    .o_rsp    (rsp_q),
    .o_retire (retire)
  );

  // Retire as the entry enters the output stage, so the ack cycle itself
  // can accept the next request (MAX_OUT per LATENCY cycles).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_q + CNT_W'(acc) - CNT_W'(retire);
  end

  assign o_ack   = rsp_q.valid & ~rsp_q.err;
  assign o_rdata = rsp_q.rdata;
`ifdef AIB_WB_RSP_ADDR_ERR_EN
  assign o_err   = rsp_q.valid & rsp_q.err;
`else
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_aib_wb_rsp.sv
// Bench for aib_wb_rsp: two configurations (LAT 2/OUT 2 and LAT 4/OUT 1)
// checked each cycle against a queue-based transaction model.
module tb_aib_wb_rsp;

  localparam int NI = 2;
  localparam int QD = 1024;
`ifdef AIB_WB_RSP_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  sel   [NI];
  logic        stall [NI];
  logic        ack   [NI];
  logic        err   [NI];
  logic [31:0] rdata [NI];

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  bit gaps = 1'b0;

  logic        q_we    [NI][QD];
  logic [31:0] q_addr  [NI][QD];
  logic [31:0] q_wdata [NI][QD];
  logic [3:0]  q_sel   [NI][QD];
  int          q_hd [NI];
  int          q_tl [NI];
  int          e_due [NI][QD];
  logic        e_err [NI][QD];
  logic [31:0] e_dat [NI][QD];
  int          e_hd [NI];
  int          e_tl [NI];
  logic [31:0] mem_m [NI][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aib_wb_rsp #(.ADDR_W(8), .LATENCY(2), .MAX_OUT(2)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_sel(sel[0]), .i_wdata(wdata[0]), .o_stall(stall[0]), .o_ack(ack[0]),
    .o_rdata(rdata[0]), .o_err(err[0]));

  aib_wb_rsp #(.ADDR_W(8), .LATENCY(4), .MAX_OUT(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_sel(sel[1]), .i_wdata(wdata[1]), .o_stall(stall[1]), .o_ack(ack[1]),
    .o_rdata(rdata[1]), .o_err(err[1]));

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int mo_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic addr_bad(logic [31:0] a);
    return ERR_EN && (a[31:10] != 22'd0);
  endfunction

  function automatic bit busy();
    bit b = 1'b0;
    for (int i = 0; i < NI; i++)
      if (q_hd[i] < q_tl[i] || e_hd[i] < e_tl[i]) b = 1'b1;
    return b;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s d%0d cyc=%0d got=%h want=%h", tag, i, cyc, got, want);
  endtask

  task automatic push_all(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    for (int i = 0; i < NI; i++) begin
      q_we[i][q_tl[i]] = w;
      q_addr[i][q_tl[i]] = a;
      q_wdata[i][q_tl[i]] = d;
      q_sel[i][q_tl[i]] = s;
      q_tl[i]++;
    end
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_stall"}, i, 32'(stall[i]), 32'd0);
      chk({tag, "_ack"}, i, 32'(ack[i]), 32'd0);
      chk({tag, "_err"}, i, 32'(err[i]), 32'd0);
      chk({tag, "_rdata"}, i, rdata[i], 32'd0);
    end
  endtask

  // One cycle: check outputs against the model, then present the next request.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int live;
      logic x_ack, x_err;
      logic [31:0] x_dat;
      live = 0; x_ack = 1'b0; x_err = 1'b0; x_dat = 32'd0;
      for (int j = e_hd[i]; j < e_tl[i]; j++) if (e_due[i][j] > cyc) live++;
      if (e_hd[i] < e_tl[i] && e_due[i][e_hd[i]] == cyc) begin
        x_err = e_err[i][e_hd[i]];
        x_ack = !x_err;
        x_dat = e_dat[i][e_hd[i]];
        e_hd[i]++;
      end
      chk("stall", i, 32'(stall[i]), 32'(live == mo_of(i)));
      chk("ack", i, 32'(ack[i]), 32'(x_ack));
      chk("err", i, 32'(err[i]), 32'(x_err));
      if (x_ack || x_err) chk("rdata", i, rdata[i], x_dat);
      stb[i] = 1'b0;
      if (q_hd[i] < q_tl[i] && !(gaps && $urandom_range(3) == 0)) begin
        int h;
        logic bad;
        logic [7:0] w;
        h = q_hd[i];
        stb[i] = 1'b1; we[i] = q_we[i][h]; addr[i] = q_addr[i][h];
        wdata[i] = q_wdata[i][h]; sel[i] = q_sel[i][h];
        if (live < mo_of(i)) begin
          bad = addr_bad(q_addr[i][h]);
          w = q_addr[i][h][9:2];
          e_due[i][e_tl[i]] = cyc + lat_of(i);
          e_err[i][e_tl[i]] = bad;
          e_dat[i][e_tl[i]] = (bad || q_we[i][h]) ? 32'd0 : mem_m[i][w];
          if (q_we[i][h] && !bad)
            for (int b = 0; b < 4; b++)
              if (q_sel[i][h][b]) mem_m[i][w][8*b +: 8] = q_wdata[i][h][8*b +: 8];
          e_tl[i]++;
          q_hd[i]++;
        end
      end
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    assert (!busy()) n_pass++;
    else $error("FAIL drain_timeout got=busy want=idle after %0d cycles", n);
    repeat (2) step();
  endtask

  // Reset lands mid-cycle, just after an edge, while responses are in flight.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      stb[i] = 1'b0;
      q_hd[i] = q_tl[i];
      e_hd[i] = e_tl[i];
    end
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      stb[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; sel[i] = 4'd0;
      q_hd[i] = 0; q_tl[i] = 0; e_hd[i] = 0; e_tl[i] = 0;
    end
    #1 rst_n = 1'b0;
    #2 chk_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) push_all(1'b1, 32'(w * 4), $urandom, 4'hF);
    drain(400);

    push_all(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    push_all(1'b0, 32'h10, 32'd0, 4'hF);
    drain(100);

    push_all(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
    push_all(1'b0, 32'h10, 32'd0, 4'h0);
    drain(100);

    for (int k = 0; k < 4; k++) push_all(1'b0, 32'(k * 4), 32'd0, 4'hF);
    drain(100);

    push_all(1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF);
    push_all(1'b0, 32'h0, 32'd0, 4'hF);
    push_all(1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0);
    push_all(1'b0, 32'h14, 32'd0, 4'hF);
    drain(100);

    gaps = 1'b1;
    repeat (150) begin
      logic [31:0] a;
      a = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'd0;
      a = a | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      push_all(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
    end
    drain(3000);
    gaps = 1'b0;

    push_all(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    drain(100);
    push_all(1'b0, 32'h20, 32'd0, 4'hF);
    push_all(1'b0, 32'h24, 32'd0, 4'hF);
    step();
    step();
    mid_reset();
    repeat (4) step();
    push_all(1'b0, 32'h20, 32'd0, 4'hF);
    push_all(1'b0, 32'h10, 32'd0, 4'hF);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
